// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (instruction/data ports), the arbiter and Memoria.
// The arbiter takes the slave modport; the requester/memory side takes the master modport.
interface mem_arbiter_if;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        wr0, wr1;
  logic [31:0] wdata0, wdata1;
  logic        lock0, lock1;
  logic        gnt0, gnt1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        lock_err;

  modport slave (
    input  req0, req1, addr0, addr1, wr0, wr1, wdata0, wdata1, lock0, lock1, mem_dout,
    output gnt0, gnt1, ack0, ack1, rdata, mem_addr, mem_wr, mem_din, lock_err
  );

  modport master (
    output req0, req1, addr0, addr1, wr0, wr1, wdata0, wdata1, lock0, lock1, mem_dout,
    input  gnt0, gnt1, ack0, ack1, rdata, mem_addr, mem_wr, mem_din, lock_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with lock (atomic sequence) support and READ_LAT read pipeline.
// Define MEM_ARB_LOCK_TIMEOUT_EN to force-release a lock left idle for LOCK_TIMEOUT cycles.
module mem_arbiter #(
  parameter int READ_LAT     = 1,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, LOCKED} state_e;

  state_e      state_q;
  logic [1:0]  gnt_q;
  logic [1:0]  ack_q;
  logic        owner_q;
  logic        last_q;
  logic        wr_q;
  logic        mem_wr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;
  logic [31:0] rdata_q;
  logic [2:0]  wait_cnt_q;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
  logic [7:0]  lock_cnt_q;
  logic        lock_err_q;
`endif

  logic        owner_d;
  logic        win_wr;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        cur_req;
  logic        cur_lock;

  // In IDLE the winner is chosen here; elsewhere ownership stays with the current owner.
  always_comb begin
    owner_d = owner_q;
    if (state_q == IDLE) begin
      if (bus.req0 && bus.req1) owner_d = ~last_q;
      else                      owner_d = bus.req1;
    end
    win_addr  = owner_d ? bus.addr1  : bus.addr0;
    win_wr    = owner_d ? bus.wr1    : bus.wr0;
    win_wdata = owner_d ? bus.wdata1 : bus.wdata0;
    cur_req   = owner_q ? bus.req1   : bus.req0;
    cur_lock  = owner_q ? bus.lock1  : bus.lock0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      ack_q      <= 2'b00;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
`endif
    end else begin
      ack_q    <= 2'b00;
      mem_wr_q <= 1'b0;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
      lock_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner_q    <= owner_d;
            last_q     <= owner_d;
            gnt_q      <= owner_d ? 2'b10 : 2'b01;
            mem_addr_q <= win_addr;
            mem_din_q  <= win_wdata;
            wr_q       <= win_wr;
            mem_wr_q   <= win_wr;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (wr_q) begin
            ack_q   <= gnt_q;
            state_q <= RESP;
          end else begin
            wait_cnt_q <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 3'(READ_LAT - 1)) begin
            rdata_q <= bus.mem_dout;
            ack_q   <= gnt_q;
            state_q <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        RESP: begin
          if (cur_lock) begin
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
            lock_cnt_q <= '0;
`endif
            state_q <= LOCKED;
          end else begin
            gnt_q   <= 2'b00;
            state_q <= IDLE;
          end
        end
        LOCKED: begin
          // A dropped lock takes priority over a new request from the owner.
          if (!cur_lock) begin
            gnt_q   <= 2'b00;
            state_q <= IDLE;
          end else if (cur_req) begin
            mem_addr_q <= win_addr;
            mem_din_q  <= win_wdata;
            wr_q       <= win_wr;
            mem_wr_q   <= win_wr;
            state_q    <= ACCESS;
          end
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
          else if (lock_cnt_q == 8'(LOCK_TIMEOUT - 1)) begin
            gnt_q      <= 2'b00;
            lock_err_q <= 1'b1;
            last_q     <= owner_q;
            state_q    <= IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0     = gnt_q[0];
  assign bus.gnt1     = gnt_q[1];
  assign bus.ack0     = ack_q[0];
  assign bus.ack1     = ack_q[1];
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_din  = mem_din_q;
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
  assign bus.lock_err = lock_err_q;
`else
  assign bus.lock_err = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter READ_LAT, default 1: cycles from mem_addr presented to mem_dout valid (1..7).
REQ-002 Parameter LOCK_TIMEOUT, default 16: maximum idle cycles a lock may be held (1..255).
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req0, req1  in  1 each  access request; port 0 = instruction fetch, port 1 = data.
- addr0, addr1  in  32 each  byte address.
- wr0, wr1  in  1 each  1 = write, 0 = read.
- wdata0, wdata1  in  32 each  write data.
- lock0, lock1  in  1 each  keep grant after ack (atomic sequence, e.g. XCHG).
- gnt0, gnt1  out  1 each  port owns memory.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- rdata  out  32  read data, valid with ack, held until next read ack.
- mem_addr  out  32  address to Memoria.
- mem_wr  out  1  write strobe to Memoria.
- mem_din  out  32  write data to Memoria.
- mem_dout  in  32  read data from Memoria.
- lock_err  out  1  one-cycle pulse on forced lock release.

Function
REQ-004 States SHALL be IDLE, ACCESS, WAIT, RESP, LOCKED; one-hot gnt asserted in every state except IDLE.
REQ-005 IDLE: if any req, latch winner's addr/wr/wdata, assert its gnt, go ACCESS next cycle; no req -> stay IDLE.
REQ-006 Both req in IDLE: grant the port not served last (round robin); last-served initialised to port 1, so port 0 wins first.
REQ-007 ACCESS: drive latched addr on mem_addr; write -> mem_wr=1 for exactly this cycle, mem_din=latched wdata, go RESP; read -> go WAIT.
REQ-008 WAIT: count READ_LAT cycles; capture mem_dout into rdata on the last WAIT cycle, then go RESP.
REQ-009 RESP: assert owner's ack for exactly one cycle; go LOCKED if owner's lock=1, else IDLE with gnt cleared.
REQ-010 Requester SHALL hold req/addr/wr/wdata stable until ack; arbiter ignores req during ACCESS/WAIT/RESP.
REQ-011 LOCKED: owner req=1 -> latch and go ACCESS (no arbitration); owner lock=0 -> IDLE; other port blocked throughout.
REQ-012 Single read latency = 2 + READ_LAT cycles from req sample to ack; write = 2 cycles.
REQ-013 mem_addr SHALL hold the last latched address in every state; mem_wr SHALL be 0 outside ACCESS.
REQ-014 rdata unchanged by write transactions.
REQ-015 Simultaneous lock drop and new req from owner in LOCKED: lock=0 wins, go IDLE, re-arbitrate next cycle.

Reset
REQ-016 reset low SHALL immediately force IDLE, gnt0=gnt1=0, ack0=ack1=0, mem_wr=0, mem_addr=0, mem_din=0, rdata=0, lock_err=0, last-served=port 1, counters 0.
REQ-017 Reset mid-transaction SHALL abandon it without ack; no write strobe after reset assertion.

Configuration
REQ-018 Macro MEM_ARB_LOCK_TIMEOUT_EN defined: counter runs in LOCKED while owner req=0; on reaching LOCK_TIMEOUT, force IDLE, pulse lock_err one cycle, set last-served = owner; counter clears on entering LOCKED.
REQ-019 Macro undefined: no counter; LOCKED held until owner drops lock; lock_err tied 0.

Verification
REQ-020 Read port 0, addr=0x10, mem holds 0xDEADBEEF, READ_LAT=1 -> gnt0 next cycle, ack0 3 cycles after req, rdata=0xDEADBEEF.
REQ-021 Write port 1, addr=0x20, wdata=0x12345678 -> mem_wr=1 for one cycle, mem_addr=0x20, ack1 2 cycles after req, readback returns 0x12345678.
REQ-022 req0 and req1 held continuously after reset -> grant order 0,1,0,1; neither port served twice in a row.
REQ-023 XCHG sequence port 1 with lock1=1: read 0x40 then write 0x40 while req0 held -> gnt0 stays 0 until lock1 drops; then port 0 granted.
REQ-024 Macro defined, LOCK_TIMEOUT=16, lock1=1, req1=0 -> lock_err pulse after 16 LOCKED cycles, gnt1=0, pending req0 granted next.
REQ-025 reset low during WAIT of a read -> all outputs zero same cycle, no ack; after release, fresh request completes normally.
